// File: rtl/phase_timer.sv
// phase_timer: per-phase countdown timer feeding main_fsm's time_out.
//
// Each time main_fsm enters a phase, the timer reloads that phase's budget.
// It then counts down one second every TICK_DIV clocks, and each rising edge
// of the penalty input removes PENALTY_SEC. The remaining time goes to the
// display path in binary and as two BCD digits.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset, sampled on rising clk
//   current_state  main_fsm state (0 IDLE, 1-4 PHASE1-4, 5 SUCCESS, 6 FAIL)
//   game_enable    counting allowed
//   timer_reset    force reload with the phase-1 budget
//   penalty        failure level; only its rising edge costs time
//   remain_sec     remaining seconds, binary (registered)
//   sec_tens       BCD tens digit of remain_sec (combinational from register)
//   sec_ones       BCD ones digit of remain_sec (combinational from register)
//   sec_tick       one-cycle pulse on each one-second decrement
//   warning        remain_sec in 1..WARN_SEC while game_enable
//   time_out       level; budget exhausted, held until reload
module phase_timer #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned P1_SEC      = 60,
  parameter int unsigned P2_SEC      = 50,
  parameter int unsigned P3_SEC      = 40,
  parameter int unsigned P4_SEC      = 30,
  parameter int unsigned PENALTY_SEC = 5,
  parameter int unsigned WARN_SEC    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] current_state,
  input  logic       game_enable,
  input  logic       timer_reset,
  input  logic       penalty,
  output logic [6:0] remain_sec,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       warning,
  output logic       time_out
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = 7;
  localparam int unsigned DW = 8;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] P1_BUDGET   = RW'(P1_SEC);
  localparam logic [RW-1:0] P2_BUDGET   = RW'(P2_SEC);
  localparam logic [RW-1:0] P3_BUDGET   = RW'(P3_SEC);
  localparam logic [RW-1:0] P4_BUDGET   = RW'(P4_SEC);
  localparam logic [DW-1:0] PENALTY_DEC = DW'(PENALTY_SEC);
  localparam logic [DW-1:0] WARN_LVL    = DW'(WARN_SEC);

  localparam logic [2:0] ST_PHASE1 = 3'd1;
  localparam logic [2:0] ST_PHASE2 = 3'd2;
  localparam logic [2:0] ST_PHASE3 = 3'd3;
  localparam logic [2:0] ST_PHASE4 = 3'd4;

  logic [PW-1:0] prescaler;
  logic [2:0]    prev_state;
  logic          penalty_prev;

  logic [PW-1:0] prescaler_nxt;
  logic [RW-1:0] remain_nxt;
  logic          tick_nxt;
  logic          warn_nxt;
  logic          time_out_nxt;

  logic          pen_edge;
  logic          in_phase;
  logic          phase_entry;
  logic          tick;
  logic [RW-1:0] entry_budget;
  logic [DW-1:0] dec;

  // A held penalty level costs time only once.
  assign pen_edge    = penalty & ~penalty_prev;
  assign in_phase    = (current_state >= ST_PHASE1) && (current_state <= ST_PHASE4);
  assign phase_entry = in_phase && (current_state != prev_state);

  // Budget for the phase being entered.
  always_comb begin
    entry_budget = P1_BUDGET;
    case (current_state)
      ST_PHASE1: entry_budget = P1_BUDGET;
      ST_PHASE2: entry_budget = P2_BUDGET;
      ST_PHASE3: entry_budget = P3_BUDGET;
      ST_PHASE4: entry_budget = P4_BUDGET;
      default:   entry_budget = P1_BUDGET;
    endcase
  end

  // Next-state logic: reload > phase entry > counting > hold.
  always_comb begin
    prescaler_nxt = prescaler;
    remain_nxt    = remain_sec;
    time_out_nxt  = time_out;
    tick_nxt      = 1'b0;
    tick          = 1'b0;
    dec           = '0;

    if (timer_reset) begin
      remain_nxt    = P1_BUDGET;
      prescaler_nxt = '0;
      time_out_nxt  = 1'b0;
    end else if (phase_entry) begin
      // A penalty edge or tick landing on the entry cycle is dropped.
      remain_nxt    = entry_budget;
      prescaler_nxt = '0;
      time_out_nxt  = 1'b0;
    end else if (game_enable && !time_out) begin
      tick          = (prescaler == PRESC_LAST);
      prescaler_nxt = tick ? '0 : prescaler + PW'(1);
      tick_nxt      = tick;
      dec           = DW'(tick) + (pen_edge ? PENALTY_DEC : DW'(0));
      // Saturating subtract; reaching zero raises time_out on the same edge.
      if ({1'b0, remain_sec} > dec) begin
        remain_nxt = remain_sec - dec[RW-1:0];
      end else begin
        remain_nxt = '0;
      end
      time_out_nxt = (remain_nxt == '0);
    end

    warn_nxt = game_enable && !time_out_nxt && (remain_nxt != '0) &&
               ({1'b0, remain_nxt} <= WARN_LVL);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain_sec   <= P1_BUDGET;
      prescaler    <= '0;
      sec_tick     <= 1'b0;
      warning      <= 1'b0;
      time_out     <= 1'b0;
      prev_state   <= '0;
      penalty_prev <= 1'b0;
    end else begin
      remain_sec   <= remain_nxt;
      prescaler    <= prescaler_nxt;
      sec_tick     <= tick_nxt;
      warning      <= warn_nxt;
      time_out     <= time_out_nxt;
      prev_state   <= current_state;
      penalty_prev <= penalty;
    end
  end

  // BCD split of the registered count for the display path.
  assign sec_tens = 4'(remain_sec / 7'd10);
  assign sec_ones = 4'(remain_sec % 7'd10);

endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: self-checking bench for phase_timer with TICK_DIV=4.
// Every driven cycle pushes the reference result to a queue that a negedge
// monitor pops and compares; spec-level checkpoints are also checked directly.
module tb_phase_timer;

  localparam int unsigned TICK_DIV = 4;
  localparam int P1 = 60, P2 = 50, P3 = 40, P4 = 30, PEN = 5, WARN = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] current_state = 3'd0;
  logic       game_enable = 1'b0;
  logic       timer_reset = 1'b0;
  logic       penalty = 1'b0;
  logic [6:0] remain_sec;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_tick;
  logic       warning;
  logic       time_out;

  phase_timer #(
    .TICK_DIV(TICK_DIV), .P1_SEC(60), .P2_SEC(50), .P3_SEC(40), .P4_SEC(30),
    .PENALTY_SEC(5), .WARN_SEC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state),
    .game_enable(game_enable), .timer_reset(timer_reset), .penalty(penalty),
    .remain_sec(remain_sec), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .sec_tick(sec_tick), .warning(warning), .time_out(time_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int remain;
    int tens;
    int ones;
    bit tick;
    bit warn;
    bit tout;
  } exp_t;

  typedef struct {
    logic       r;
    logic [2:0] st;
    logic       en;
    logic       trst;
    logic       pen;
    int         cycles;
    int         exp_remain;
    logic       exp_to;
  } seg_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_remain = P1;
  int m_presc  = 0;
  int m_prev   = 0;
  bit m_to = 0, m_tick = 0, m_warn = 0, m_penp = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int budget(input int st);
    case (st)
      1: return P1;
      2: return P2;
      3: return P3;
      default: return P4;
    endcase
  endfunction

  // Behavioural next-cycle model of the timer.
  task automatic model(input bit r, input int st, input bit en, input bit trst, input bit pen);
    bit pe;
    int dec;
    if (!r) begin
      m_remain = P1; m_presc = 0; m_to = 0; m_tick = 0; m_warn = 0;
      m_prev = 0; m_penp = 0;
      return;
    end
    pe = pen && !m_penp;
    m_tick = 0;
    if (trst) begin
      m_remain = P1; m_presc = 0; m_to = 0;
    end else if (st >= 1 && st <= 4 && st != m_prev) begin
      m_remain = budget(st); m_presc = 0; m_to = 0;
    end else if (en && !m_to) begin
      m_presc = m_presc + 1;
      if (m_presc == TICK_DIV) begin
        m_presc = 0;
        m_tick = 1;
      end
      dec = (m_tick ? 1 : 0) + (pe ? PEN : 0);
      m_remain = (m_remain > dec) ? m_remain - dec : 0;
      if (m_remain == 0) m_to = 1;
    end
    m_warn = en && !m_to && m_remain >= 1 && m_remain <= WARN;
    m_prev = st;
    m_penp = pen;
  endtask

  // Drive one cycle, record the expected result, return at posedge+1.
  task automatic step(input logic r, input logic [2:0] st, input logic en,
                      input logic trst, input logic pen);
    exp_t e;
    rst_n = r; current_state = st; game_enable = en; timer_reset = trst; penalty = pen;
    model(r, int'(st), en, trst, pen);
    e.remain = m_remain; e.tens = m_remain / 10; e.ones = m_remain % 10;
    e.tick = m_tick; e.warn = m_warn; e.tout = m_to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) step(1'b1, st, 1'b1, 1'b0, 1'b0);
  endtask

  // n single-cycle penalty pulses, each followed by one quiet cycle.
  task automatic pulses(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, st, 1'b1, 1'b0, 1'b1);
      step(1'b1, st, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_rem(input string name, input int req_rem, input logic req_to);
    chk({name, ".remain"}, 8'(remain_sec), 8'(req_rem));
    chk({name, ".time_out"}, 8'(time_out), 8'(req_to));
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb.remain",   8'(remain_sec), 8'(e.remain));
      chk("sb.tens",     8'(sec_tens),   8'(e.tens));
      chk("sb.ones",     8'(sec_ones),   8'(e.ones));
      chk("sb.sec_tick", 8'(sec_tick),   8'(e.tick));
      chk("sb.warning",  8'(warning),    8'(e.warn));
      chk("sb.time_out", 8'(time_out),   8'(e.tout));
    end
  end

  initial begin
    seg_t tbl[5];
    tbl[0] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2, 60, 1'b0};
    tbl[1] = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1, 60, 1'b0};
    tbl[2] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1, 60, 1'b0};
    tbl[3] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 4, 59, 1'b0};
    tbl[4] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 4, 58, 1'b0};

    // Reset, reload, phase-1 entry and basic counting.
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++)
        step(tbl[i].r, tbl[i].st, tbl[i].en, tbl[i].trst, tbl[i].pen);
      chk_rem($sformatf("tbl%0d", i), tbl[i].exp_remain, tbl[i].exp_to);
      if (i == 0) begin
        chk("reset.tens", 8'(sec_tens), 8'd6);
        chk("reset.ones", 8'(sec_ones), 8'd0);
        chk("reset.warning", 8'(warning), 8'd0);
        chk("reset.sec_tick", 8'(sec_tick), 8'd0);
      end
    end
    chk("t1.ones", 8'(sec_ones), 8'd8);
    chk("t1.sec_tick", 8'(sec_tick), 8'd1);

    // Penalty coincident with tick, warning window, time_out.
    pulses(3'd1, 7);
    chk_rem("t3.at20", 20, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    chk_rem("t3.tick_pen", 14, 1'b0);
    chk("t3.tick", 8'(sec_tick), 8'd1);
    chk("t3.warn14", 8'(warning), 8'd0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    run(3'd1, 14);
    chk_rem("t3.at11", 11, 1'b0);
    chk("t3.warn11", 8'(warning), 8'd0);
    run(3'd1, 1);
    chk_rem("t3.at10", 10, 1'b0);
    chk("t3.warn10", 8'(warning), 8'd1);
    run(3'd1, 40);
    chk_rem("t3.timeout", 0, 1'b1);
    chk("t3.warn_to", 8'(warning), 8'd0);
    run(3'd1, 8);
    chk_rem("t3.held", 0, 1'b1);

    // Reload, reach 37, then phase change with a penalty edge in that cycle.
    step(1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    chk_rem("t4.reload", 60, 1'b0);
    pulses(3'd1, 4);
    run(3'd1, 4);
    chk_rem("t4.at37", 37, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    chk_rem("t4.entry", 50, 1'b0);
    run(3'd2, 3);
    chk_rem("t4.no_tick", 50, 1'b0);
    run(3'd2, 1);
    chk_rem("t4.first_tick", 49, 1'b0);

    // Disable mid-count with prescaler at 2.
    pulses(3'd2, 4);
    run(3'd2, 10);
    chk_rem("t5.at25", 25, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 3'd2, 1'b0, 1'b0, (i == 5) ? 1'b1 : 1'b0);
    chk_rem("t5.frozen", 25, 1'b0);
    run(3'd2, 1);
    chk_rem("t5.reen1", 25, 1'b0);
    run(3'd2, 1);
    chk_rem("t5.reen2", 24, 1'b0);
    chk("t5.tick", 8'(sec_tick), 8'd1);

    // Held penalty at remain=3 saturates to 0 exactly once.
    pulses(3'd2, 3);
    run(3'd2, 18);
    chk_rem("t2.at3", 3, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    chk_rem("t2.sat", 0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    chk_rem("t2.held", 0, 1'b1);
    chk("t2.no_tick", 8'(sec_tick), 8'd0);
    run(3'd2, 4);

    // Synchronous reset mid-count at remain=12.
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    chk_rem("t6.entry", 40, 1'b0);
    pulses(3'd3, 5);
    run(3'd3, 3);
    chk_rem("t6.at12", 12, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    chk_rem("t6.glitch", 12, 1'b0);
    step(1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    chk_rem("t6.reset", 60, 1'b0);
    chk("t6.sec_tick", 8'(sec_tick), 8'd0);
    chk("t6.warning", 8'(warning), 8'd0);
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    chk_rem("t6.reentry", 40, 1'b0);
    run(3'd3, 4);
    chk_rem("t6.tick", 39, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
